// File: rtl/divider_array_remul_seq.sv
// Rebuilds a dividend n_rec = q*d + r with a shift-add multiplier, one q bit per cycle (REMUL_ERR_EN adds n_ref/err_abs).
// Latency: out_valid rises exactly W clocks after the accept edge, with no early exit.
// Backpressure: a single request is in flight; in_ready stays low and n_rec is held until out_ready takes the result.
module divider_array_remul_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   q,
    input  logic [W-1:0]   d,
    input  logic [W-1:0]   r,
`ifdef REMUL_ERR_EN
    input  logic [2*W-1:0] n_ref,
    output logic [2*W-1:0] err_abs,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] n_rec,
    output logic           busy
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    q_reg;
    logic [W-1:0]    d_reg;
    logic [2*W-1:0]  acc;
    logic [2*W-1:0]  sum;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            last_bit;

    assign accept   = in_valid && in_ready;
    assign last_bit = (cnt == CW'(W - 1));

    // Partial product for the current quotient bit; the 2W width cannot overflow.
    assign sum = acc + (q_reg[cnt] ? ({{W{1'b0}}, d_reg} << cnt) : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef REMUL_ERR_EN
    logic [2*W-1:0] n_ref_reg;
    logic [2*W-1:0] diff;

    assign diff = (n_ref_reg >= sum) ? (n_ref_reg - sum) : (sum - n_ref_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            n_ref_reg <= '0;
            err_abs   <= '0;
        end else begin
            if (accept) begin
                n_ref_reg <= n_ref;
            end
            if (state == MUL && last_bit) begin
                err_abs <= diff;
            end
        end
    end
`endif

    // Operands are captured only at the accept edge; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
            d_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            n_rec <= '0;
        end else if (accept) begin
            q_reg <= q;
            d_reg <= d;
            acc   <= {{W{1'b0}}, r};
            cnt   <= '0;
        end else if (state == MUL) begin
            acc <= sum;
            cnt <= cnt + CW'(1);
            if (last_bit) begin
                n_rec <= sum;
            end
        end
    end
endmodule
